// File: rtl/audio_pkg.sv
// Shared audio definitions used by the PWM output stage and the tone/oscillator sources.
package audio_pkg;

  localparam int SAMPLE_W = 16;

  typedef enum logic {OFF, RUN} pwm_state_e;

  // Signed two's-complement to offset binary: flipping the MSB maps -32768..32767 onto 0..65535.
  function automatic logic [SAMPLE_W-1:0] to_offset(input logic signed [SAMPLE_W-1:0] sample);
    return $unsigned(sample) ^ {1'b1, {(SAMPLE_W-1){1'b0}}};
  endfunction

  function automatic logic [SAMPLE_W-1:0] midscale(input int bits);
    return SAMPLE_W'(1) << (bits - 1);
  endfunction

endpackage

// File: rtl/audio_pwm_out_if.sv
// Sample stream from a PCM producer into the PWM output stage.
interface audio_pwm_out_if;
  import audio_pkg::*;

  logic signed [SAMPLE_W-1:0] sample_in;
  logic                       sample_valid;
  logic                       sample_ready;

  modport master (output sample_in, output sample_valid, input sample_ready);
  modport slave  (input sample_in, input sample_valid, output sample_ready);

endinterface

// File: rtl/audio_pwm_counter.sv
// Frame counter and registered PWM comparator; frame_tick marks the last clock of each frame.
module audio_pwm_counter #(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic [PWM_BITS-1:0] duty,
  output logic                frame_tick,
  output logic                pwm_out
);

  logic [PWM_BITS-1:0] cnt;

  assign frame_tick = run && (&cnt);

  // The compare at cnt == max can never be true, so a full-scale duty still drops low one clock per frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      pwm_out <= 1'b0;
    end else begin
      cnt     <= run ? cnt + PWM_BITS'(1) : '0;
      pwm_out <= run && (cnt < duty);
    end
  end

endmodule

// File: rtl/audio_pwm_out.sv
// PCM-to-PWM output stage: one-entry sample holding register, per-frame duty update, amp shutdown, underrun flag.
module audio_pwm_out
  import audio_pkg::*;
#(
  parameter int PWM_BITS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  audio_pwm_out_if.slave   smp,
  input  logic             underrun_clr,
  output logic             pwm_out,
  output logic             sd_n,
  output logic             frame_tick,
  output logic             underrun
);

  localparam logic [PWM_BITS-1:0] MID = PWM_BITS'(midscale(PWM_BITS));

  pwm_state_e          state, state_next;
  logic                run;
  logic                hold_full;
  logic [PWM_BITS-1:0] hold_duty;
  logic [PWM_BITS-1:0] duty;
  logic [PWM_BITS-1:0] sample_duty;
  logic                accept;
  logic                load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= OFF;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    run        = 1'b0;
    case (state)
      OFF: begin
        if (en) state_next = RUN;
      end
      RUN: begin
        run = 1'b1;
        if (!en) state_next = OFF;
      end
      default: state_next = OFF;
    endcase
  end

  assign sd_n             = run;
  assign smp.sample_ready = ~hold_full;
  assign accept           = smp.sample_valid && !hold_full;
  assign load             = frame_tick && hold_full;
  assign sample_duty      = PWM_BITS'(to_offset(smp.sample_in) >> (SAMPLE_W - PWM_BITS));

  // A sample arriving on the boundary cycle lands in the hold and waits for the next boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_full <= 1'b0;
      hold_duty <= '0;
    end else if (load) begin
      hold_full <= 1'b0;
    end else if (accept) begin
      hold_full <= 1'b1;
      hold_duty <= sample_duty;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       duty <= MID;
    else if (!run) duty <= MID;
    else if (load) duty <= hold_duty;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          underrun <= 1'b0;
    else if (frame_tick && !hold_full) underrun <= 1'b1;
    else if (underrun_clr)            underrun <= 1'b0;
  end

  audio_pwm_counter #(.PWM_BITS(PWM_BITS)) u_counter (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .duty       (duty),
    .frame_tick (frame_tick),
    .pwm_out    (pwm_out)
  );

endmodule

// File: tb/tb_audio_pwm_out.sv
// Directed bench for audio_pwm_out: an 8-bit instance for most scenarios plus a 4-bit instance.
module tb_audio_pwm_out;

  logic clk, rst;
  logic en, underrun_clr, pwm_out, sd_n, frame_tick, underrun;
  logic en4, clr4, pwm4, sd_n4, tick4, underrun4;

  audio_pwm_out_if smp ();
  audio_pwm_out_if smp4 ();

  audio_pwm_out #(.PWM_BITS(8)) dut (
    .clk(clk), .rst(rst), .en(en), .smp(smp), .underrun_clr(underrun_clr),
    .pwm_out(pwm_out), .sd_n(sd_n), .frame_tick(frame_tick), .underrun(underrun)
  );

  audio_pwm_out #(.PWM_BITS(4)) dut4 (
    .clk(clk), .rst(rst), .en(en4), .smp(smp4), .underrun_clr(clr4),
    .pwm_out(pwm4), .sd_n(sd_n4), .frame_tick(tick4), .underrun(underrun4)
  );

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic sync_tick();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_tick && n < 600);
    checks++;
    if (frame_tick !== 1'b1) begin
      errors++;
      $display("FAIL sync_tick: frame_tick=%b after %0d cycles, required 1", frame_tick, n);
    end
  endtask

  // Counts pwm_out over the 256 cycles following a frame_tick; ends on the next frame_tick.
  task automatic measure(input bit offer, input logic [15:0] s, output int highs);
    highs = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      highs += int'(pwm_out);
      if (offer && i == 10) begin
        smp.sample_in    = s;
        smp.sample_valid = 1'b1;
      end
      if (i == 11) smp.sample_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; underrun_clr = 1'b0;
    en4 = 1'b0; clr4 = 1'b0;
    smp.sample_in = '0; smp.sample_valid = 1'b0;
    smp4.sample_in = '0; smp4.sample_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({pwm_out, sd_n, frame_tick, underrun} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs: pwm,sd_n,tick,underrun=%b required 0000", {pwm_out, sd_n, frame_tick, underrun});
    end
    checks++;
    if (smp.sample_ready !== 1'b1 || smp4.sample_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: ready=%b ready4=%b required 1 1", smp.sample_ready, smp4.sample_ready);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({pwm_out, sd_n, frame_tick} !== 3'b000) begin
      errors++;
      $display("FAIL off_idle: pwm,sd_n,tick=%b required 000", {pwm_out, sd_n, frame_tick});
    end
  endtask

  task automatic test_midscale();
    int highs;
    en = 1'b1;
    @(negedge clk);
    checks++;
    if (sd_n !== 1'b1) begin
      errors++;
      $display("FAIL run_sd_n: sd_n=%b required 1", sd_n);
    end
    highs = int'(pwm_out);
    for (int i = 0; i < 255; i++) begin
      @(negedge clk);
      highs += int'(pwm_out);
    end
    checks++;
    if (frame_tick !== 1'b1) begin
      errors++;
      $display("FAIL first_tick: frame_tick=%b required 1", frame_tick);
    end
    checks++;
    if (highs !== 128) begin
      errors++;
      $display("FAIL midscale_frame: high=%0d required 128", highs);
    end
    @(negedge clk);
    checks++;
    if (underrun !== 1'b1) begin
      errors++;
      $display("FAIL underrun_first_boundary: underrun=%b required 1", underrun);
    end
    underrun_clr = 1'b1;
    @(negedge clk);
    underrun_clr = 1'b0;
    checks++;
    if (underrun !== 1'b0) begin
      errors++;
      $display("FAIL underrun_clr: underrun=%b required 0", underrun);
    end
    smp.sample_in = 16'h0FFF; smp.sample_valid = 1'b1;
    @(negedge clk);
    smp.sample_valid = 1'b0;
    checks++;
    if (smp.sample_ready !== 1'b0) begin
      errors++;
      $display("FAIL hold_accept: ready=%b required 0", smp.sample_ready);
    end
    sync_tick();
  endtask

  task automatic test_stream();
    int highs;
    measure(1'b1, 16'h8FFF, highs);
    checks++;
    if (highs !== 143) begin
      errors++;
      $display("FAIL stream_0fff: high=%0d required 143", highs);
    end
    measure(1'b1, 16'h8000, highs);
    checks++;
    if (highs !== 15) begin
      errors++;
      $display("FAIL stream_8fff: high=%0d required 15", highs);
    end
    checks++;
    if (underrun !== 1'b0) begin
      errors++;
      $display("FAIL stream_no_underrun: underrun=%b required 0", underrun);
    end
    measure(1'b1, 16'h7FFF, highs);
    checks++;
    if (highs !== 0) begin
      errors++;
      $display("FAIL extreme_8000: high=%0d required 0", highs);
    end
    measure(1'b0, 16'h0000, highs);
    checks++;
    if (highs !== 255) begin
      errors++;
      $display("FAIL extreme_7fff: high=%0d required 255", highs);
    end
  endtask

  task automatic test_withhold();
    int highs;
    measure(1'b0, 16'h0000, highs);
    checks++;
    if (highs !== 255) begin
      errors++;
      $display("FAIL withhold_repeat: high=%0d required 255", highs);
    end
    checks++;
    if (underrun !== 1'b1) begin
      errors++;
      $display("FAIL withhold_underrun: underrun=%b required 1", underrun);
    end
    // On a starved boundary, clear and set collide: set must win.
    underrun_clr = 1'b1;
    @(negedge clk);
    checks++;
    if (underrun !== 1'b1) begin
      errors++;
      $display("FAIL clr_vs_set: underrun=%b required 1", underrun);
    end
    @(negedge clk);
    underrun_clr = 1'b0;
    checks++;
    if (underrun !== 1'b0) begin
      errors++;
      $display("FAIL clr_plain: underrun=%b required 0", underrun);
    end
  endtask

  task automatic test_boundary_transfer();
    int highs;
    sync_tick();
    smp.sample_in = 16'h0FFF; smp.sample_valid = 1'b1;
    @(negedge clk);
    smp.sample_valid = 1'b0;
    checks++;
    if (smp.sample_ready !== 1'b0) begin
      errors++;
      $display("FAIL boundary_accept: ready=%b required 0", smp.sample_ready);
    end
    checks++;
    if (underrun !== 1'b1) begin
      errors++;
      $display("FAIL boundary_underrun: underrun=%b required 1", underrun);
    end
    highs = int'(pwm_out);
    for (int i = 0; i < 255; i++) begin
      @(negedge clk);
      highs += int'(pwm_out);
    end
    checks++;
    if (highs !== 255) begin
      errors++;
      $display("FAIL boundary_not_used: high=%0d required 255", highs);
    end
    measure(1'b0, 16'h0000, highs);
    checks++;
    if (highs !== 143) begin
      errors++;
      $display("FAIL boundary_next_frame: high=%0d required 143", highs);
    end
  endtask

  task automatic test_back_to_back();
    int highs;
    bit stuck;
    repeat (2) @(negedge clk);
    smp.sample_in = 16'h8000; smp.sample_valid = 1'b1;
    @(negedge clk);
    smp.sample_in = 16'h7FFF;
    stuck = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (smp.sample_ready !== 1'b0) stuck = 1'b0;
      @(negedge clk);
    end
    smp.sample_valid = 1'b0;
    checks++;
    if (stuck !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_ready: ready rose while hold full, required 0");
    end
    sync_tick();
    measure(1'b1, 16'h7FFF, highs);
    checks++;
    if (highs !== 0) begin
      errors++;
      $display("FAIL backpressure_no_overwrite: high=%0d required 0", highs);
    end
  endtask

  task automatic test_en_off();
    int highs;
    bit quiet;
    repeat (20) @(negedge clk);
    checks++;
    if (pwm_out !== 1'b1) begin
      errors++;
      $display("FAIL full_duty_high: pwm=%b required 1", pwm_out);
    end
    en = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({pwm_out, sd_n, frame_tick} !== 3'b000) begin
      errors++;
      $display("FAIL en_off: pwm,sd_n,tick=%b required 000", {pwm_out, sd_n, frame_tick});
    end
    quiet = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (pwm_out !== 1'b0 || frame_tick !== 1'b0) quiet = 1'b0;
    end
    checks++;
    if (quiet !== 1'b1) begin
      errors++;
      $display("FAIL off_quiet: pwm or frame_tick toggled while off, required 0");
    end
    en = 1'b1;
    highs = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      highs += int'(pwm_out);
    end
    checks++;
    if (highs !== 128 || frame_tick !== 1'b1) begin
      errors++;
      $display("FAIL restart_midscale: high=%0d tick=%b required 128 1", highs, frame_tick);
    end
  endtask

  task automatic test_rst_mid();
    int highs;
    repeat (2) @(negedge clk);
    smp.sample_in = 16'h7FFF; smp.sample_valid = 1'b1;
    @(negedge clk);
    smp.sample_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({pwm_out, sd_n, frame_tick, underrun} !== 4'b0000) begin
      errors++;
      $display("FAIL async_rst_outputs: pwm,sd_n,tick,underrun=%b required 0000", {pwm_out, sd_n, frame_tick, underrun});
    end
    checks++;
    if (smp.sample_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_rst_ready: ready=%b required 1", smp.sample_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    highs = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      highs += int'(pwm_out);
    end
    checks++;
    if (highs !== 128) begin
      errors++;
      $display("FAIL rst_first_frame: high=%0d required 128", highs);
    end
    measure(1'b0, 16'h0000, highs);
    checks++;
    if (highs !== 128) begin
      errors++;
      $display("FAIL rst_hold_discarded: high=%0d required 128", highs);
    end
  endtask

  task automatic test_pwm4();
    int highs;
    smp4.sample_in = 16'h7FFF; smp4.sample_valid = 1'b1;
    @(negedge clk);
    smp4.sample_valid = 1'b0;
    checks++;
    if (smp4.sample_ready !== 1'b0) begin
      errors++;
      $display("FAIL pwm4_hold_in_off: ready=%b required 0", smp4.sample_ready);
    end
    en4 = 1'b1;
    highs = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      highs += int'(pwm4);
    end
    checks++;
    if (highs !== 8 || tick4 !== 1'b1) begin
      errors++;
      $display("FAIL pwm4_midscale: high=%0d tick=%b required 8 1", highs, tick4);
    end
    highs = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      highs += int'(pwm4);
      if (i == 3) begin
        smp4.sample_in = 16'h0FFF;
        smp4.sample_valid = 1'b1;
      end
      if (i == 4) smp4.sample_valid = 1'b0;
    end
    checks++;
    if (highs !== 15 || tick4 !== 1'b1) begin
      errors++;
      $display("FAIL pwm4_7fff: high=%0d tick=%b required 15 1", highs, tick4);
    end
    highs = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      highs += int'(pwm4);
    end
    checks++;
    if (highs !== 8 || tick4 !== 1'b1) begin
      errors++;
      $display("FAIL pwm4_0fff: high=%0d tick=%b required 8 1", highs, tick4);
    end
  endtask

  initial begin
    test_reset();
    test_midscale();
    test_stream();
    test_withhold();
    test_boundary_transfer();
    test_back_to_back();
    test_en_off();
    test_rst_mid();
    test_pwm4();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
